// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter: round-robin arbiter sharing one 16-bit graphics memory read port
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   ch_address   per-channel word addresses, channel i at [i*AW +: AW]
//   ch_rvalid    per-channel read requests, held until that channel's rready
//   ch_rready    one-cycle completion strobe, one-hot or zero
//   ch_data      read data for the channel whose ch_rready is high
//   mem_address  downstream address
//   mem_rvalid   downstream request
//   mem_data     downstream data
//   mem_rready   downstream data valid strobe
//   grant_id     channel currently owning the port
//   timeout_err  sticky flag, set when a read is forced complete
module gfx_mem_arbiter #(
   parameter int N_CH    = 4,
   parameter int AW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_CH*AW-1:0] ch_address,
   input  logic [N_CH-1:0]   ch_rvalid,
   output logic [N_CH-1:0]   ch_rready,
   output logic [15:0]       ch_data,
   output logic [AW-1:0]     mem_address,
   output logic              mem_rvalid,
   input  logic [15:0]       mem_data,
   input  logic              mem_rready,
   output logic [2:0]        grant_id,
   output logic              timeout_err
);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t            state, state_nxt;
   logic [2:0]        rr, rr_nxt, pick, grant_nxt;
   logic [3:0]        sum;
   logic [N_CH-1:0]   rot, rready_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic [15:0]       data_nxt;
   logic [AW-1:0]     addr_nxt;
   logic              found, done, rvalid_nxt, err_nxt;

   // Rotate requests so bit 0 is the channel at the RR pointer; the lowest set
   // bit of the rotated vector is then the next channel in round-robin order.
   always_comb begin
      rot   = N_CH'({ch_rvalid, ch_rvalid} >> rr);
      found = 1'b0;
      pick  = rr;
      sum   = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr} + 4'(k);
            pick  = (sum >= 4'(N_CH)) ? 3'(sum - 4'(N_CH)) : sum[2:0];
         end
      end
   end

   // Real data beats the timeout when both land in the same cycle.
   assign done = mem_rready || (cnt == 8'(TIMEOUT));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = found ? REQ : IDLE;
         REQ:     state_nxt = done ? RESP : REQ;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs and datapath.
   always_comb begin
      rvalid_nxt = (state == IDLE && found) || (state == REQ && !done);
      addr_nxt   = (state == IDLE && found) ? ch_address[int'(pick)*AW +: AW] : mem_address;
      grant_nxt  = (state == IDLE && found) ? pick : grant_id;
      rready_nxt = (state == REQ && done) ? N_CH'(1) << grant_id : '0;
      data_nxt   = (state == REQ && done) ? (mem_rready ? mem_data : 16'h0000) : ch_data;
      err_nxt    = timeout_err || (state == REQ && !mem_rready && cnt == 8'(TIMEOUT));
      cnt_nxt    = (state == REQ) ? cnt + 8'd1 : 8'd0;
      rr_nxt     = (state != RESP) ? rr : (grant_id == 3'(N_CH - 1)) ? 3'd0 : grant_id + 3'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ch_rready   <= '0;
         ch_data     <= '0;
         mem_address <= '0;
         mem_rvalid  <= 1'b0;
         grant_id    <= '0;
         timeout_err <= 1'b0;
         cnt         <= '0;
         rr          <= '0;
      end else begin
         ch_rready   <= rready_nxt;
         ch_data     <= data_nxt;
         mem_address <= addr_nxt;
         mem_rvalid  <= rvalid_nxt;
         grant_id    <= grant_nxt;
         timeout_err <= err_nxt;
         cnt         <= cnt_nxt;
         rr          <= rr_nxt;
      end
   end
endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb_gfx_mem_arbiter: randomized and directed bench against a cycle-level reference model
module tb_gfx_mem_arbiter;
   localparam int N = 4;
   localparam int AW = 16;
   localparam int TO = 255;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*AW-1:0] ch_address;
   logic [N-1:0]    ch_rvalid, ch_rready;
   logic [15:0]     ch_data, mem_data;
   logic [AW-1:0]   mem_address;
   logic            mem_rvalid, mem_rready;
   logic [2:0]      grant_id;
   logic            timeout_err;

   always #5 clk = ~clk;

   gfx_mem_arbiter #(.N_CH(N), .AW(AW), .TIMEOUT(TO)) dut (
      .CLK(clk), .RST(rst), .ch_address(ch_address), .ch_rvalid(ch_rvalid),
      .ch_rready(ch_rready), .ch_data(ch_data), .mem_address(mem_address),
      .mem_rvalid(mem_rvalid), .mem_data(mem_data), .mem_rready(mem_rready),
      .grant_id(grant_id), .timeout_err(timeout_err)
   );

   int checks = 0, errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: phase 0 = port free, 1 = read outstanding, 2 = response cycle.
   int phase, age, dly, g, rr, mode, fix_dly, next_dly, fix_data, cyc;
   logic [15:0]   m_data;
   logic          m_err;
   logic [AW-1:0] m_addr;
   // Observed events
   logic          prev_mv;
   int            t_rise, t_rdy, lat;
   logic [N-1:0]  last_rdy;
   int            rcnt [N];
   int            gq [$], tq [$];

   function automatic int pick(input logic [N-1:0] rq);
      for (int k = 0; k < N; k++)
         if (rq[(rr + k) % N]) return (rr + k) % N;
      return 0;
   endfunction

   function automatic int rand_dly();
      int r;
      r = $urandom_range(0, 39);
      return (r == 0) ? 256 : (r == 1) ? 300 : $urandom_range(1, 6);
   endfunction

   task automatic step();
      logic [N-1:0]    rq, er;
      logic            mr;
      logic [15:0]     md;
      logic [N*AW-1:0] ad;
      rq = ch_rvalid; mr = mem_rready; md = mem_data; ad = ch_address; er = '0;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (phase == 0) begin
         if (|rq) begin
            g = pick(rq);
            m_addr = ad[g*AW +: AW];
            phase = 1;
            age = 0;
            dly = (fix_dly > 0) ? fix_dly : (next_dly > 0) ? next_dly : rand_dly();
            next_dly = 0;
         end
      end else if (phase == 1) begin
         age++;
         if (mr) begin
            m_data = md; er = N'(1) << g; phase = 2;
         end else if (age == TO + 1) begin
            m_data = 16'h0000; m_err = 1'b1; er = N'(1) << g; phase = 2;
         end
      end else begin
         rr = (g + 1) % N;
         phase = 0;
      end
      check("mem_rvalid", mem_rvalid, phase == 1);
      check("ch_rready", ch_rready, er);
      check("ch_data", ch_data, m_data);
      check("timeout_err", timeout_err, m_err);
      if (phase != 0) check("grant_id", grant_id, g);
      if (phase == 1) check("mem_address", mem_address, m_addr);
      if (mem_rvalid && !prev_mv) begin
         t_rise = cyc; gq.push_back(int'(grant_id)); tq.push_back(cyc);
      end
      prev_mv = mem_rvalid;
      if (ch_rready != 0) begin
         last_rdy = ch_rready; t_rdy = cyc; lat = t_rdy - t_rise;
      end
      for (int i = 0; i < N; i++) begin
         if (ch_rready[i]) rcnt[i]++;
         if (er[i]) ch_rvalid[i] = 1'b0;
         else if (!ch_rvalid[i]) begin
            ch_address[i*AW +: AW] = 16'($urandom);
            if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) ch_rvalid[i] = 1'b1;
         end
      end
      if (mode == 1 && phase == 1 && ch_rvalid[g] && $urandom_range(0, 9) == 0) begin
         ch_rvalid[g] = 1'b0;
         ch_address[g*AW +: AW] = 16'($urandom);
      end
      mem_rready = (phase == 1 && age + 1 == dly);
      mem_data = (fix_data >= 0) ? 16'(fix_data) : 16'($urandom);
   endtask

   task automatic drain(input int lim);
      int n = 0;
      while ((ch_rvalid != 0 || phase != 0) && n < lim) begin
         step();
         n++;
      end
      check("drain_bound", n < lim, 1'b1);
   endtask

   task automatic model_reset();
      phase = 0; rr = 0; g = 0; age = 0; m_data = '0; m_err = 1'b0; prev_mv = 1'b0;
   endtask

   initial begin
      int n2;
      ch_address = '0; ch_rvalid = '0; mem_rready = 1'b0; mem_data = '0; rst = 1'b1;
      mode = 0; fix_dly = 0; next_dly = 0; fix_data = -1; cyc = 0;
      t_rise = 0; t_rdy = 0; lat = 0; last_rdy = '0;
      for (int i = 0; i < N; i++) rcnt[i] = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_mem_rvalid", mem_rvalid, 1'b0);
      check("rst_ch_rready", ch_rready, '0);
      check("rst_ch_data", ch_data, '0);
      check("rst_mem_address", mem_address, '0);
      check("rst_grant_id", grant_id, '0);
      check("rst_timeout_err", timeout_err, 1'b0);
      rst = 1'b0;

      // Single request on ch1 with a 4-cycle memory
      ch_address[1*AW +: AW] = 16'h1234; ch_rvalid = 4'b0010; next_dly = 4; fix_data = 16'hBEEF;
      step();
      check("t1_addr", mem_address, 16'h1234);
      check("t1_grant", grant_id, 1);
      drain(50);
      check("t1_rready", last_rdy, 4'b0010);
      check("t1_data", ch_data, 16'hBEEF);
      check("t1_latency", lat, 4);

      // mem_rready on exactly the timeout cycle
      ch_rvalid = 4'b0001; next_dly = 256; fix_data = 16'hA5A5;
      drain(400);
      check("t4_data", ch_data, 16'hA5A5);
      check("t4_err", timeout_err, 1'b0);
      check("t4_latency", lat, 256);
      fix_data = -1;

      // All channels requesting, zero-wait memory
      gq.delete(); tq.delete();
      mode = 2; fix_dly = 1; ch_rvalid = '1;
      repeat (24) step();
      n2 = gq.size();
      mode = 0; fix_dly = 0;
      drain(100);
      check("t2_grants", n2, 8);
      for (int j = 1; j < n2; j++) begin
         check("t2_order", gq[j], (gq[j-1] + 1) % N);
         check("t2_spacing", tq[j] - tq[j-1], 3);
      end

      // Memory never answers
      ch_rvalid = 4'b0100; next_dly = 300;
      drain(400);
      check("t3_data", ch_data, 16'h0000);
      check("t3_err", timeout_err, 1'b1);
      check("t3_latency", lat, 256);
      repeat (5) step();
      check("t3_sticky", timeout_err, 1'b1);

      // Asynchronous reset mid-transaction
      ch_rvalid = 4'b0001; next_dly = 300;
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      check("t5_mem_rvalid", mem_rvalid, 1'b0);
      check("t5_ch_rready", ch_rready, '0);
      check("t5_err", timeout_err, 1'b0);
      check("t5_grant", grant_id, '0);
      check("t5_addr", mem_address, '0);
      check("t5_data", ch_data, '0);
      model_reset();
      mem_rready = 1'b0;
      @(negedge clk);
      check("t5_no_rready", ch_rready, '0);
      rst = 1'b0;
      next_dly = 2;
      step();
      check("t5_regrant", grant_id, 0);
      check("t5_regrant_valid", mem_rvalid, 1'b1);
      drain(100);

      // Granted channel drops rvalid mid-read while another waits
      gq.delete(); rcnt[2] = 0;
      ch_rvalid = 4'b1100; next_dly = 6;
      step();
      check("t6_grant", grant_id, 2);
      repeat (2) step();
      ch_rvalid[2] = 1'b0;
      drain(100);
      check("t6_rready2", rcnt[2], 1);
      check("t6_ngrants", gq.size(), 2);
      if (gq.size() == 2) check("t6_next", gq[1], 3);

      // Random traffic
      mode = 1;
      repeat (3000) step();
      mode = 0;
      drain(3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
